// File: rtl/tb_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_sequencer
//
// Schedules test-vector playback in the DUT clock domain. Instead of
// free-running read/write clocks, it emits single-cycle strobes once per
// sample period (CLK_DIV DUT cycles). It also counts samples, keeps issuing
// write periods after the last read so the DUT pipeline drains, and counts
// checker mismatches.
//
// Ports
//   clk          in   DUT clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a run (honoured in IDLE/DONE only)
//   abort        in   terminate the current run (honoured while busy)
//   vector_size  in   number of samples, latched on start
//   mismatch     in   checker compare result, used when check_en=1
//   read_en      out  one-cycle strobe: fetch sample sample_idx
//   write_en     out  one-cycle strobe: log DUT outputs
//   check_en     out  write_en once the pipeline-fill writes are past
//   sample_idx   out  index of the current/next sample read
//   busy         out  high in INIT, RUN and DRAIN
//   done         out  high in DONE
//   pass         out  run finished with no mismatch and no abort
//   aborted      out  run was terminated by abort
//   err_count    out  saturating mismatch count
// ---------------------------------------------------------------------------
module tb_vector_sequencer #(
  parameter int CLK_DIV      = 10,
  parameter int WRITE_OFFSET = 5,
  parameter int INIT_CYCLES  = 4,
  parameter int PIPE_SAMPLES = 2,
  parameter int SIZE_W       = 32,
  parameter int ERR_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SIZE_W-1:0] vector_size,
  input  logic              mismatch,
  output logic              read_en,
  output logic              write_en,
  output logic              check_en,
  output logic [SIZE_W-1:0] sample_idx,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int PH_W = $clog2(CLK_DIV);
  localparam int IC_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int SK_W = (PIPE_SAMPLES > 0) ? $clog2(PIPE_SAMPLES + 1) : 1;

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_WR     = PH_W'(WRITE_OFFSET);
  localparam logic [IC_W-1:0]   INIT_LAST = IC_W'(INIT_CYCLES - 1);
  localparam logic [SIZE_W:0]   PIPE_TOT  = (SIZE_W + 1)'(PIPE_SAMPLES);
  localparam logic [SK_W-1:0]   SKIP_INIT = SK_W'(PIPE_SAMPLES);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    sat_inc = (&v) ? v : v + ERR_W'(1);
  endfunction

  logic [2:0]        state;
  logic [PH_W-1:0]   phase;
  logic [IC_W-1:0]   init_cnt;
  logic [SIZE_W-1:0] n_lat;
  logic [SIZE_W-1:0] rd_cnt;
  logic [SIZE_W:0]   wr_cnt;
  logic [SK_W-1:0]   skip_left;

  logic [SIZE_W-1:0] rd_issued;
  logic [SIZE_W:0]   wr_issued;
  logic [SIZE_W:0]   wr_total;
  logic              reads_done;
  logic              last_wr;
  logic              new_write;
  logic [ERR_W-1:0]  err_next;

  // The counters advance the cycle after their strobe, so a strobe still on
  // the wire has to be added in to know how many transfers are committed.
  always_comb begin
    rd_issued  = rd_cnt + SIZE_W'(read_en);
    wr_issued  = wr_cnt + (SIZE_W + 1)'(write_en);
    wr_total   = {1'b0, n_lat} + PIPE_TOT;
    reads_done = (rd_issued == n_lat);
    last_wr    = write_en && (wr_issued == wr_total);
    new_write  = (phase == PH_WR) && (wr_issued < wr_total);
    err_next   = (check_en && mismatch) ? sat_inc(err_count) : err_count;
  end

  assign sample_idx = rd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase     <= '0;
      init_cnt  <= '0;
      n_lat     <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      skip_left <= '0;
      read_en   <= 1'b0;
      write_en  <= 1'b0;
      check_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      aborted   <= 1'b0;
      err_count <= '0;
    end else begin
      read_en  <= 1'b0;
      write_en <= 1'b0;
      check_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            n_lat     <= vector_size;
            err_count <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            skip_left <= SKIP_INIT;
            phase     <= '0;
            init_cnt  <= '0;
            aborted   <= 1'b0;
            if (vector_size == '0) begin
              // Empty vector: nothing to play, finish clean immediately.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_INIT;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end

        S_INIT: begin
          if (abort) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            aborted <= 1'b1;
          end else if (init_cnt == INIT_LAST) begin
            state <= S_RUN;
            phase <= '0;
          end else begin
            init_cnt <= init_cnt + IC_W'(1);
          end
        end

        S_RUN, S_DRAIN: begin
          if (abort) begin
            // Counters stay frozen so the abort point can be inspected.
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            if (read_en)  rd_cnt <= rd_cnt + SIZE_W'(1);
            if (write_en) wr_cnt <= wr_cnt + (SIZE_W + 1)'(1);
            err_count <= err_next;
            phase     <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            if (last_wr) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              if ((state == S_RUN) && reads_done && (phase == PH_LAST))
                state <= S_DRAIN;
              read_en  <= (state == S_RUN) && (phase == '0) && !reads_done;
              write_en <= new_write;
              // The first PIPE_SAMPLES writes only flush the DUT pipeline.
              check_en <= new_write && (skip_left == '0);
              if (new_write && (skip_left != '0))
                skip_left <= skip_left - SK_W'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_vector_sequencer.sv
// Directed bench for tb_vector_sequencer. Instance "dut" uses the nominal
// configuration (CLK_DIV=4, WRITE_OFFSET=2, INIT_CYCLES=3, PIPE_SAMPLES=1);
// instance "sat" uses ERR_W=2, PIPE_SAMPLES=0 for the saturation case.
module tb_tb_vector_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] vector_size;
  logic        mismatch;
  logic        read_en, write_en, check_en, busy, done, pass, aborted;
  logic [31:0] sample_idx;
  logic [15:0] err_count;

  logic        start_b;
  logic        mismatch_b;
  logic        read_en_b, write_en_b, check_en_b, busy_b, done_b, pass_b, aborted_b;
  logic [31:0] sample_idx_b;
  logic [1:0]  err_count_b;

  int tests;
  int fails;

  tb_vector_sequencer #(
    .CLK_DIV(4), .WRITE_OFFSET(2), .INIT_CYCLES(3), .PIPE_SAMPLES(1),
    .SIZE_W(32), .ERR_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vector_size(vector_size), .mismatch(mismatch),
    .read_en(read_en), .write_en(write_en), .check_en(check_en),
    .sample_idx(sample_idx), .busy(busy), .done(done), .pass(pass),
    .aborted(aborted), .err_count(err_count)
  );

  tb_vector_sequencer #(
    .CLK_DIV(4), .WRITE_OFFSET(2), .INIT_CYCLES(3), .PIPE_SAMPLES(0),
    .SIZE_W(32), .ERR_W(2)
  ) sat (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .vector_size(vector_size), .mismatch(mismatch_b),
    .read_en(read_en_b), .write_en(write_en_b), .check_en(check_en_b),
    .sample_idx(sample_idx_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .aborted(aborted_b), .err_count(err_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_rd"},   {31'd0, read_en},  32'd0);
    chk({pfx, "_wr"},   {31'd0, write_en}, 32'd0);
    chk({pfx, "_ck"},   {31'd0, check_en}, 32'd0);
    chk({pfx, "_idx"},  sample_idx,        32'd0);
    chk({pfx, "_busy"}, {31'd0, busy},     32'd0);
    chk({pfx, "_done"}, {31'd0, done},     32'd0);
    chk({pfx, "_pass"}, {31'd0, pass},     32'd0);
    chk({pfx, "_abt"},  {31'd0, aborted},  32'd0);
    chk({pfx, "_err"},  {16'd0, err_count}, 32'd0);
  endtask

  // Expected outputs of the nominal N=3 run, sampled 1 time unit after edge e
  // (start sampled at edge 0).
  task automatic check_nominal(input int e, input logic mm);
    logic        rd_x, wr_x, ck_x;
    logic [31:0] idx_x, err_x;
    rd_x  = (e == 4) || (e == 8) || (e == 12);
    wr_x  = (e == 6) || (e == 10) || (e == 14) || (e == 18);
    ck_x  = (e == 10) || (e == 14) || (e == 18);
    idx_x = (e < 5) ? 32'd0 : (e < 9) ? 32'd1 : (e < 13) ? 32'd2 : 32'd3;
    if (!mm)         err_x = 32'd0;
    else if (e < 11) err_x = 32'd0;
    else if (e < 15) err_x = 32'd1;
    else if (e < 19) err_x = 32'd2;
    else             err_x = 32'd3;
    chk($sformatf("rd_e%0d", e),   {31'd0, read_en},  {31'd0, rd_x});
    chk($sformatf("wr_e%0d", e),   {31'd0, write_en}, {31'd0, wr_x});
    chk($sformatf("ck_e%0d", e),   {31'd0, check_en}, {31'd0, ck_x});
    chk($sformatf("idx_e%0d", e),  sample_idx,        idx_x);
    chk($sformatf("busy_e%0d", e), {31'd0, busy},     {31'd0, (e <= 18)});
    chk($sformatf("done_e%0d", e), {31'd0, done},     {31'd0, (e >= 19)});
    chk($sformatf("pass_e%0d", e), {31'd0, pass},     {31'd0, (e >= 19) && !mm});
    chk($sformatf("abt_e%0d", e),  {31'd0, aborted},  32'd0);
    chk($sformatf("err_e%0d", e),  {16'd0, err_count}, err_x);
  endtask

  task automatic nominal(input logic mm, input logic poke);
    vector_size = 32'd3;
    mismatch    = mm;
    start       = 1'b1;
    for (int e = 0; e <= 21; e++) begin
      @(posedge clk); #1;
      if (e == 0) start = 1'b0;
      check_nominal(e, mm);
      // A start pulse while busy (with a different size) must be ignored.
      if (poke && e == 6) begin start = 1'b1; vector_size = 32'd7; end
      if (poke && e == 7) begin start = 1'b0; vector_size = 32'd3; end
    end
    mismatch = 1'b0;
  endtask

  initial begin
    int cyc;
    tests       = 0;
    fails       = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    vector_size = 32'd0;
    mismatch    = 1'b0;
    start_b     = 1'b0;
    mismatch_b  = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal run, clean
    nominal(1'b0, 1'b0);
    // Nominal run with mismatch held high: first write unchecked
    nominal(1'b1, 1'b0);
    // Start pulse mid-RUN is ignored
    nominal(1'b0, 1'b1);

    // Abort: raised after edge 9, sampled at edge 10
    vector_size = 32'd3;
    start       = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      @(posedge clk); #1;
      if (e == 0) start = 1'b0;
      check_nominal(e, 1'b0);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abt_done",  {31'd0, done},    32'd1);
    chk("abt_flag",  {31'd0, aborted}, 32'd1);
    chk("abt_pass",  {31'd0, pass},    32'd0);
    chk("abt_busy",  {31'd0, busy},    32'd0);
    for (int e = 10; e <= 20; e++) begin
      if (e > 10) begin @(posedge clk); #1; end
      chk($sformatf("abt_rd_e%0d", e),  {31'd0, read_en},  32'd0);
      chk($sformatf("abt_wr_e%0d", e),  {31'd0, write_en}, 32'd0);
      chk($sformatf("abt_idx_e%0d", e), sample_idx,        32'd2);
    end
    chk("abt_hold_done", {31'd0, done},    32'd1);
    chk("abt_hold_flag", {31'd0, aborted}, 32'd1);

    // Zero-length vector
    vector_size = 32'd0;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done", {31'd0, done},    32'd1);
    chk("zero_pass", {31'd0, pass},    32'd1);
    chk("zero_abt",  {31'd0, aborted}, 32'd0);
    chk("zero_busy", {31'd0, busy},    32'd0);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      chk($sformatf("zero_rd_e%0d", e), {31'd0, read_en},  32'd0);
      chk($sformatf("zero_wr_e%0d", e), {31'd0, write_en}, 32'd0);
    end

    // Saturation on the ERR_W=2 instance: 10 checked writes, count stops at 3
    vector_size = 32'd10;
    mismatch_b  = 1'b1;
    start_b     = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("sat_done_edge", cyc,                   32'd43);
    chk("sat_err",       {30'd0, err_count_b},  32'd3);
    chk("sat_pass",      {31'd0, pass_b},       32'd0);
    chk("sat_abt",       {31'd0, aborted_b},    32'd0);
    chk("sat_idx",       sample_idx_b,          32'd10);
    mismatch_b = 1'b0;

    // Async reset during DRAIN (write_en high at edge 18)
    vector_size = 32'd3;
    mismatch    = 1'b1;
    start       = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      @(posedge clk); #1;
      if (e == 0) start = 1'b0;
      check_nominal(e, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    mismatch = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    nominal(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tb_vector_sequencer.md
Name: tb_vector_sequencer

Overview:
- Synthesizable scheduler that sequences test-vector playback in the verification environment.
- Runs in the DUT clock domain. Derives single-cycle read and write strobes at the sample rate, which replace free-running reading/writing clocks.
- Counts samples, drains the DUT pipeline after the last sample, and counts checker mismatches.
- Reports done, pass and abort status to the testbench top.

Parameters:
- CLK_DIV, 10: DUT clock cycles per sample period; legal range ≥2.
- WRITE_OFFSET, 5: cycle within the period at which write_en fires; legal range 0..CLK_DIV-1.
- INIT_CYCLES, 4: settle cycles between start and the first read; legal range ≥1.
- PIPE_SAMPLES, 2: extra write periods issued after the last read to cover DUT latency; legal range ≥0.
- SIZE_W, 32: width of the sample counters.
- ERR_W, 16: width of the error counter.

Ports:
- clk, in, 1: DUT clock; all logic on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin a run; sampled in IDLE or DONE only.
- abort, in, 1: terminate the current run.
- vector_size, in, SIZE_W: number of samples; latched on start.
- mismatch, in, 1: checker compare result; sampled only when check_en=1.
- read_en, out, 1: one-cycle strobe; fetch sample sample_idx.
- write_en, out, 1: one-cycle strobe; log outputs.
- check_en, out, 1: write_en qualified with compare-valid.
- sample_idx, out, SIZE_W: index of the current/next sample read.
- busy, out, 1: high in INIT, RUN and DRAIN.
- done, out, 1: level; high in DONE.
- pass, out, 1: valid while done=1.
- aborted, out, 1: valid while done=1.
- err_count, out, ERR_W: saturating count of mismatches.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0.
  - State IDLE.
  - Phase, read and write counters 0.
- Registered outputs: every output is registered; strobes are driven from the state and phase register.
- FSM states: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE/DONE, on start=1:
  - Latch vector_size into N.
  - Clear err_count, sample_idx, rd_cnt and wr_cnt.
  - Clear done, pass and aborted.
  - Go to INIT.
  - If N=0: go straight to DONE with pass=1 and no strobes.
- INIT:
  - Counts INIT_CYCLES cycles, then goes to RUN with phase=0.
  - The first RUN cycle is phase 0.
- Phase counter: runs 0..CLK_DIV-1 and wraps, in RUN and DRAIN only.
- RUN:
  - read_en=1 on the phase-0 cycle while rd_cnt<N.
  - rd_cnt and sample_idx increment in the cycle after read_en.
  - After the Nth read, go to DRAIN at the next phase wrap. The phase keeps counting.
- Writes (RUN and DRAIN):
  - write_en=1 on the phase==WRITE_OFFSET cycle of every period; wr_cnt increments.
  - Total writes issued = N+PIPE_SAMPLES.
  - If WRITE_OFFSET=0, read_en and write_en assert in the same cycle; this is legal.
- check_en = write_en and (wr_cnt ≥ PIPE_SAMPLES), i.e. the first PIPE_SAMPLES writes are not checked.
- Error counting:
  - mismatch=1 with check_en=1 increments err_count.
  - err_count saturates at 2^ERR_W-1 and never wraps.
- DRAIN: after write number N+PIPE_SAMPLES issues, go to DONE on the next cycle.
- DONE:
  - busy=0, done=1.
  - pass = (err_count==0) and not aborted.
  - Outputs are held until start or reset.
- abort=1 in INIT, RUN or DRAIN:
  - Go to DONE on the next edge with aborted=1 and pass=0.
  - No further strobes; counters are frozen.
- abort in IDLE or DONE: ignored.
- start while busy: ignored.
- abort and start in the same cycle: abort wins if busy; start wins in IDLE/DONE.
- rst_n asserted mid-run: immediate return to reset values; no strobe glitch is required to be suppressed beyond the reset.

Test Plan:
- Nominal timing. Config: CLK_DIV=4, WRITE_OFFSET=2, INIT_CYCLES=3, PIPE_SAMPLES=1, N=3. Stimulus: start sampled at edge 0. Required response:
  - read_en at edges 4, 8, 12 with sample_idx 0, 1, 2.
  - write_en at 6, 10, 14, 18; check_en at 10, 14, 18.
  - done=1 from edge 19; pass=1; err_count=0.
- Error counting. Same run, mismatch held at 1 throughout. Required response:
  - err_count=3, because the write at 6 is not checked.
  - pass=0, aborted=0.
- Saturation. Config: ERR_W=2, N=10, PIPE_SAMPLES=0, mismatch=1. Required response: err_count stops at 3; pass=0.
- Abort. Stimulus: abort at edge 9 of the nominal run. Required response:
  - done=1, aborted=1, pass=0 at edge 10.
  - No read_en/write_en after edge 9.
- Zero-length vector and start while busy. Required response:
  - start with N=0 → done=1, pass=1, no strobes.
  - start pulsed mid-RUN → no change to counters or timing.
- Async reset mid-DRAIN. Required response:
  - All outputs 0 immediately, without waiting for a clock edge.
  - A subsequent start runs the nominal sequence exactly as in the first scenario.
